fft_out_serializer: RTL and testbench

Downstream of the 8-point FFT stage-3 butterfly network. Captures one complete parallel frame of eight bins (y0 and y4 real-only, bins 1-3 and 5-7 complex) on a frame strobe into a two-bank ping-pong buffer. Streams the bins out one per cycle in natural order (bin 0..7) over a valid/ready handshake. Back-to-back frames stream with no bubble; a frame that arrives when no bank is free is dropped and flagged.

---
 rtl/fft_out_serializer_pkg.sv | 14 +
 rtl/fft_out_serializer_if.sv | 28 ++
 rtl/fft_frame_bank.sv | 34 +++
 rtl/fft_out_serializer.sv | 80 ++++++++
 tb/tb_fft_out_serializer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft_out_serializer_pkg.sv
// Shared FFT output types: word width, bin count and the complex word layout.
package fft_pkg;
    localparam int FFT_N     = 4;
    localparam int FFT_W     = 2 ** FFT_N;
    localparam int FFT_PTS   = 8;
    localparam int FFT_IDX_W = 3;

    typedef struct packed {
        logic [FFT_W-1:0] re;
        logic [FFT_W-1:0] im;
    } cplx_t;

    typedef cplx_t [FFT_PTS-1:0] frame_t;
endpackage

// File: rtl/fft_out_serializer_if.sv
// Parallel stage-3 frame in, serial valid/ready bin stream out, plus status.
interface fft_out_serializer_if;
    import fft_pkg::*;

    logic             in_valid;
    logic [FFT_W-1:0] y0, y4;
    logic [FFT_W-1:0] yr1, yi1, yr2, yi2, yr3, yi3;
    logic [FFT_W-1:0] yr5, yi5, yr6, yi6, yr7, yi7;
    logic             out_ready;
    logic             out_valid;
    logic [FFT_W-1:0] out_re, out_im;
    logic [2:0]       out_idx;
    logic             out_last;
    logic             busy;
    logic             ovf;

    modport slave (
        input  in_valid, y0, y4, yr1, yi1, yr2, yi2, yr3, yi3,
               yr5, yi5, yr6, yi6, yr7, yi7, out_ready,
        output out_valid, out_re, out_im, out_idx, out_last, busy, ovf
    );

    modport master (
        output in_valid, y0, y4, yr1, yi1, yr2, yi2, yr3, yi3,
               yr5, yi5, yr6, yi6, yr7, yi7, out_ready,
        input  out_valid, out_re, out_im, out_idx, out_last, busy, ovf
    );
endinterface

// File: rtl/fft_frame_bank.sv
// One 8-bin frame store: parallel write of the whole frame, indexed read, full flag.
// Write takes effect at the clock edge; read is a mux of the registered words.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  frame_t               wr_dat,
    input  logic [FFT_IDX_W-1:0] rd_idx,
    output cplx_t                rd_dat,
    input  logic                 set,
    input  logic                 clr,
    output logic                 full
);
    frame_t mem;

    // set wins over clr so a bank can be refilled on the cycle it drains
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem  <= '0;
            full <= 1'b0;
        end else begin
            if (wr_en)
                mem <= wr_dat;
            if (set)
                full <= 1'b1;
            else if (clr)
                full <= 1'b0;
        end
    end

    assign rd_dat = mem[rd_idx];
endmodule

// File: rtl/fft_out_serializer.sv
// Ping-pong capture of 8-bin FFT frames, streamed one bin per cycle; first bin valid the cycle after capture.
// Stalls hold the current bin; a frame with no free bank is dropped and sets sticky ovf.
module fft_out_serializer
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fft_out_serializer_if.slave bus
);
    logic                 wr_bank;
    logic                 rd_bank;
    logic [FFT_IDX_W-1:0] rd_idx;
    logic                 ovf_q;
    logic [1:0]           full;
    cplx_t                rd_dat [2];
    frame_t               cap_dat;
    logic                 fire;
    logic                 fin;
    logic                 tgt_free;
    logic                 cap;

    // bins 0 and 4 are real-only; their imaginary part is stored as zero
    always_comb begin
        cap_dat    = '0;
        cap_dat[0] = {bus.y0, {FFT_W{1'b0}}};
        cap_dat[1] = {bus.yr1, bus.yi1};
        cap_dat[2] = {bus.yr2, bus.yi2};
        cap_dat[3] = {bus.yr3, bus.yi3};
        cap_dat[4] = {bus.y4, {FFT_W{1'b0}}};
        cap_dat[5] = {bus.yr5, bus.yi5};
        cap_dat[6] = {bus.yr6, bus.yi6};
        cap_dat[7] = {bus.yr7, bus.yi7};
    end

    assign fire     = full[rd_bank] & bus.out_ready;
    assign fin      = fire & (rd_idx == FFT_IDX_W'(FFT_PTS - 1));
    // the target is also free when it is the streaming bank finishing this cycle
    assign tgt_free = ~full[wr_bank] | ((wr_bank == rd_bank) & fin);
    assign cap      = bus.in_valid & tgt_free;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank u_bank (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (cap & (wr_bank == 1'(b))),
            .wr_dat (cap_dat),
            .rd_idx (rd_idx),
            .rd_dat (rd_dat[b]),
            .set    (cap & (wr_bank == 1'(b))),
            .clr    (fin & (rd_bank == 1'(b))),
            .full   (full[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            rd_idx  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (cap)
                wr_bank <= ~wr_bank;
            if (bus.in_valid & ~tgt_free)
                ovf_q <= 1'b1;
            if (fire)
                rd_idx <= rd_idx + FFT_IDX_W'(1);
            if (fin)
                rd_bank <= ~rd_bank;
        end
    end

    assign bus.out_valid = full[rd_bank];
    assign bus.out_re    = rd_dat[rd_bank].re;
    assign bus.out_im    = rd_dat[rd_bank].im;
    assign bus.out_idx   = rd_idx;
    assign bus.out_last  = full[rd_bank] & (rd_idx == FFT_IDX_W'(FFT_PTS - 1));
    assign bus.busy      = |full;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench with a frame-queue reference model checked every cycle.
module tb_fft_out_serializer;
    logic clk;
    logic rst;
    fft_out_serializer_if bus();

    fft_out_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0][15:0] re;
        logic [7:0][15:0] im;
    } frm_t;

    frm_t q[$];
    int   pos    = 0;
    bit   m_ovf  = 0;
    bit   fresh  = 0;
    bit   mdl_ok = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word(input int f, input int k, input bit imag);
        logic [15:0] w;
        w = 16'(f << 12) | (imag ? 16'h0200 : 16'h0100) | 16'(k);
        return w;
    endfunction

    task automatic set_frame(input int f);
        bus.y0  = word(f, 0, 0);
        bus.yr1 = word(f, 1, 0); bus.yi1 = word(f, 1, 1);
        bus.yr2 = word(f, 2, 0); bus.yi2 = word(f, 2, 1);
        bus.yr3 = word(f, 3, 0); bus.yi3 = word(f, 3, 1);
        bus.y4  = word(f, 4, 0);
        bus.yr5 = word(f, 5, 0); bus.yi5 = word(f, 5, 1);
        bus.yr6 = word(f, 6, 0); bus.yi6 = word(f, 6, 1);
        bus.yr7 = word(f, 7, 0); bus.yi7 = word(f, 7, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: up to two stored frames in arrival order, pos = next bin.
    always @(negedge clk) begin
        frm_t nf;
        bit   ev, fire_m, fin_m;
        if (mdl_ok) begin
            ev = (q.size() > 0);
            chk("out_valid", 32'(bus.out_valid), 32'(ev));
            chk("busy", 32'(bus.busy), 32'(ev));
            chk("ovf", 32'(bus.ovf), 32'(m_ovf));
            if (ev) begin
                chk("out_re", 32'(bus.out_re), 32'(q[0].re[pos]));
                chk("out_im", 32'(bus.out_im), 32'(q[0].im[pos]));
                chk("out_idx", 32'(bus.out_idx), 32'(pos));
                chk("out_last", 32'(bus.out_last), 32'(pos == 7));
            end else begin
                chk("out_last_idle", 32'(bus.out_last), 32'd0);
            end
            if (fresh) begin
                chk("rst_re", 32'(bus.out_re), 32'd0);
                chk("rst_im", 32'(bus.out_im), 32'd0);
                chk("rst_idx", 32'(bus.out_idx), 32'd0);
            end
        end
        if (!rst) begin
            q.delete();
            pos    = 0;
            m_ovf  = 0;
            fresh  = 1;
            mdl_ok = 1;
        end else if (mdl_ok) begin
            fresh  = 0;
            ev     = (q.size() > 0);
            fire_m = ev && bus.out_ready;
            fin_m  = fire_m && (pos == 7);
            if (bus.in_valid) begin
                if (q.size() < 2 || fin_m) begin
                    nf.re[0] = bus.y0;  nf.im[0] = 16'h0;
                    nf.re[1] = bus.yr1; nf.im[1] = bus.yi1;
                    nf.re[2] = bus.yr2; nf.im[2] = bus.yi2;
                    nf.re[3] = bus.yr3; nf.im[3] = bus.yi3;
                    nf.re[4] = bus.y4;  nf.im[4] = 16'h0;
                    nf.re[5] = bus.yr5; nf.im[5] = bus.yi5;
                    nf.re[6] = bus.yr6; nf.im[6] = bus.yi6;
                    nf.re[7] = bus.yr7; nf.im[7] = bus.yi7;
                    q.push_back(nf);
                end else begin
                    m_ovf = 1;
                end
            end
            if (fire_m) begin
                if (fin_m) begin
                    void'(q.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
        end
    end

    initial begin
        int nv;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_frame(0);
        step();
        step();
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b1;
        step();

        // single frame, literal values
        set_frame(0);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("lit_valid", 32'(bus.out_valid), 32'd1);
            chk("lit_idx", 32'(bus.out_idx), 32'(k));
            chk("lit_re", 32'(bus.out_re), 32'(16'h0100 + k));
            chk("lit_im", 32'(bus.out_im), (k == 0 || k == 4) ? 32'd0 : 32'(16'h0200 + k));
            chk("lit_last", 32'(bus.out_last), 32'(k == 7));
            step();
        end
        chk("lit_done_valid", 32'(bus.out_valid), 32'd0);
        chk("lit_done_busy", 32'(bus.busy), 32'd0);

        // backpressure 1,0,0,1,...
        set_frame(1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 28; i++) begin
            bus.out_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        step();

        // back-to-back frames every 8 cycles
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = (i % 8 == 0) && (i < 32);
            if (i % 8 == 0) set_frame(2 + i / 8);
            step();
            if (i < 32 && bus.out_valid) nv++;
        end
        bus.in_valid = 1'b0;
        chk("b2b_valid_cycles", 32'(nv), 32'd32);
        chk("b2b_ovf", 32'(bus.ovf), 32'd0);

        // overflow: three frames with the consumer stalled
        bus.out_ready = 1'b0;
        for (int f = 6; f < 9; f++) begin
            set_frame(f);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        chk("ovf_head", 32'(bus.out_re), 32'h6100);
        bus.out_ready = 1'b1;
        repeat (18) step();
        chk("ovf_drained", 32'(bus.busy), 32'd0);
        chk("ovf_sticky", 32'(bus.ovf), 32'd1);

        // reset mid-stream at idx 3
        set_frame(12);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        chk("mid_idx", 32'(bus.out_idx), 32'd3);
        rst = 1'b0;
        step();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_re", 32'(bus.out_re), 32'd0);
        chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b1;
        set_frame(13);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("mid_new_re", 32'(bus.out_re), 32'hD100);
        chk("mid_new_idx", 32'(bus.out_idx), 32'd0);
        repeat (10) step();

        // capture into the bank freed by the final handshake
        bus.out_ready = 1'b0;
        set_frame(9);
        bus.in_valid = 1'b1;
        step();
        set_frame(10);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (7) step();
        chk("edge_idx7", 32'(bus.out_idx), 32'd7);
        set_frame(11);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("edge_next_re", 32'(bus.out_re), 32'hA100);
        chk("edge_ovf", 32'(bus.ovf), 32'd0);
        chk("edge_busy", 32'(bus.busy), 32'd1);
        repeat (20) step();
        chk("edge_ovf_end", 32'(bus.ovf), 32'd0);
        chk("edge_idle", 32'(bus.busy), 32'd0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
